// File: rtl/mem_byte_master_pkg.sv
// Shared load/store encodings and FSM state type for the byte-serial memory master.
// Shared with the memory model and the datapath decode logic.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RESP
    } state_e;

    // Index of the final byte of an access: 0, 1 or 3 for byte, half or word.
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_master_if.sv
// CPU request/response bundle and byte-wide memory port bundle.
// The master modport is the initiator side of each bundle.
interface mem_byte_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface mem_byte_bus_if #(
    parameter int unsigned MEM_AW = 12
);
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_byte_master_load_ext.sv
// Zero/sign extension of reassembled load data from bit 7, 15 or 31.
// Purely combinational; also used by the writeback mux.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] i_buf,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic w_sb;
    logic w_sh;

    assign w_sb = i_signed & i_buf[7];
    assign w_sh = i_signed & i_buf[15];

    always_comb begin
        o_data = i_buf;
        case (i_size)
            SZ_B:    o_data = {{24{w_sb}}, i_buf[7:0]};
            SZ_H:    o_data = {{16{w_sh}}, i_buf[15:0]};
            default: o_data = i_buf;
        endcase
    end

endmodule

// File: rtl/mem_byte_master.sv
// Load/store initiator: one CPU access per handshake, serialised into
// little-endian single-byte memory cycles, with alignment/range rejection.
module mem_byte_master
    import mem_pkg::*;
#(
    parameter int unsigned MEM_AW = 12
) (
    input  logic               clk,
    input  logic               reset,
    mem_byte_master_if.slave   cpu,
    mem_byte_bus_if.master     mem
);

    state_e            r_state;
    state_e            w_next;

    logic              r_we;
    logic              r_signed;
    logic              r_err;
    logic [1:0]        r_size;
    logic [1:0]        r_idx;
    logic [1:0]        r_last;
    logic [MEM_AW-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;

    logic              w_accept;
    logic              w_req_err;
    logic              w_last_byte;
    logic [31:0]       w_ext_data;

    assign w_accept    = (r_state == ST_IDLE) && cpu.req_valid;
    assign w_last_byte = (r_idx == r_last);

    always_comb begin
        w_req_err = 1'b0;
        if (cpu.req_size == 2'd3)
            w_req_err = 1'b1;
        if ((cpu.req_size == SZ_H) && cpu.req_addr[0])
            w_req_err = 1'b1;
        if ((cpu.req_size == SZ_W) && (cpu.req_addr[1:0] != 2'b00))
            w_req_err = 1'b1;
        if ((cpu.req_addr >> MEM_AW) != 32'd0)
            w_req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu.req_valid)
                    w_next = w_req_err ? ST_RESP : ST_XFER;
            end
            ST_XFER: begin
                if (w_last_byte)
                    w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= SZ_B;
            r_idx    <= '0;
            r_last   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_buf    <= '0;
        end else if (w_accept) begin
            r_we     <= cpu.req_we;
            r_signed <= cpu.req_signed;
            r_err    <= w_req_err;
            r_size   <= cpu.req_size;
            r_idx    <= '0;
            r_last   <= size_last(cpu.req_size);
            r_addr   <= cpu.req_addr[MEM_AW-1:0];
            r_wdata  <= cpu.req_wdata;
            r_buf    <= '0;
        end else if (r_state == ST_XFER) begin
            if (!r_we)
                r_buf[{r_idx, 3'b000} +: 8] <= mem.mem_rdata;
            if (!w_last_byte)
                r_idx <= r_idx + 2'd1;
        end
    end

    load_ext u_load_ext (
        .i_buf    (r_buf),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ext_data)
    );

    always_comb begin
        cpu.req_ready  = (r_state == ST_IDLE);
        cpu.resp_valid = 1'b0;
        cpu.resp_err   = 1'b0;
        cpu.resp_rdata = '0;
        mem.mem_addr   = '0;
        mem.mem_we     = 1'b0;
        mem.mem_wdata  = '0;
        case (r_state)
            ST_XFER: begin
                mem.mem_addr = r_addr + MEM_AW'(r_idx);
                if (r_we) begin
                    // A reset cycle aborts the store before its byte reaches memory.
                    mem.mem_we    = !reset;
                    mem.mem_wdata = r_wdata[{r_idx, 3'b000} +: 8];
                end
            end
            ST_RESP: begin
                cpu.resp_valid = 1'b1;
                cpu.resp_err   = r_err;
                if (!r_we && !r_err)
                    cpu.resp_rdata = w_ext_data;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_byte_master.md
# mem_byte_master

Load/store initiator that sits between the CPU datapath and a byte-wide data memory. It accepts one byte, halfword or word access per handshake and serialises it into single-byte memory cycles, little-endian. Loads are reassembled and zero- or sign-extended; stores are split into bytes. Misaligned or out-of-range requests return an error without touching memory.

## Interface
- `MEM_AW`, default 12: byte-address width of the memory port (memory holds 2^MEM_AW bytes).
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; takes effect on the rising edge where it is high.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 byte (sb/lb), 1 half (sh/lh), 2 word (sw/lw), 3 illegal.
- `req_signed` in 1: loads only; 1 sign-extends, 0 zero-extends.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low 8/16/32 bits are used.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected; valid while `resp_valid` is high.
- `mem_addr` out MEM_AW: byte address driven to memory.
- `mem_we` out 1: byte write strobe.
- `mem_wdata` out 8: write byte.
- `mem_rdata` in 8: combinational read of `mem_addr` in the same cycle.

## Operation
- States: IDLE, XFER, RESP.
- IDLE: `req_ready` = 1. When `req_valid` is high, the block latches `req_we`, `req_size`, `req_signed`, `req_addr` and `req_wdata`, then runs the error check:
  - `req_size` = 3 is an error.
  - Half with `addr[0]` ≠ 0 is an error.
  - Word with `addr[1:0]` ≠ 0 is an error.
  - Any request with `addr[31:MEM_AW]` ≠ 0 is an error.
  - On error, go to RESP with the error flag set. Otherwise go to XFER with byte counter `idx` = 0 and `last` = 0, 1 or 3 for byte, half or word.
- XFER, one byte per cycle:
  - `mem_addr` = `addr[MEM_AW-1:0] + idx`.
  - Store: `mem_we` = 1, `mem_wdata` = `wdata[8*idx +: 8]`.
  - Load: `mem_we` = 0; `mem_rdata` is captured into `buf[8*idx +: 8]` at the clock edge.
  - When `idx` == `last`, go to RESP; otherwise `idx` + 1.
- RESP: `resp_valid` = 1 for exactly one cycle, then go to IDLE.
  - Load: `resp_rdata` = `buf` extended from bit 7, 15 or 31 per size and `req_signed`.
  - Store or error: `resp_rdata` = 0.
- `mem_we` is 0 in every state except a store in XFER. `mem_addr` and `mem_wdata` are 0 outside XFER.
- No response backpressure. The CPU must consume the `resp_valid` pulse.

## Timing
- Reset: state = IDLE, `idx` = 0, `buf` = 0. Outputs after reset: `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- A request presented in a cycle where `reset` is high is ignored.
- Request accepted at edge N (`req_valid` && `req_ready`): XFER occupies cycles N+1 .. N+k, with k = 1, 2 or 4 bytes. `resp_valid` is high in cycle N+k+1. `req_ready` is high again in cycle N+k+2.
- An error request accepted at edge N gives `resp_valid` with `resp_err` = 1 in cycle N+1.
- Back-to-back requests: throughput is one request per k+2 cycles. `req_valid` held high while `req_ready` = 0 is not accepted and is not lost; the CPU keeps it asserted.
- Reset mid-XFER: the next cycle is IDLE with `mem_we` = 0 and no `resp_valid`. Bytes already written stay written; partial load data is discarded.
- Address arithmetic: `addr + idx` is computed in MEM_AW bits. An aligned, in-range request never wraps.

## Structure
- Shared package `mem_pkg`:
  - Size encodings `SZ_B` = 0, `SZ_H` = 1, `SZ_W` = 2.
  - The IDLE/XFER/RESP state type.
  - Shared with the memory and decode logic.
- One sub-module: `load_ext`, combinational. Inputs `buf`[31:0], size and signed; output the 32-bit extended value. It is reused by the datapath writeback mux.

## Test plan
- sw: addr 0x10, data 0x8899AABB -> `mem_we` on 4 consecutive cycles at 0x10..0x13 with bytes BB, AA, 99, 88; `resp_valid` 5 cycles after accept, `resp_err` = 0.
- lw, lh signed and lhu at 0x10, 0x12 and 0x12 after the store above -> 0x8899AABB, 0xFFFF8899, 0x00008899; lb at 0x10 -> 0xFFFFFFBB; lbu -> 0x000000BB.
- lh at 0x11, sw at 0x12, size 3, and lw at 0x1000 -> each gives `resp_err` = 1 the cycle after accept, no `mem_we` pulse, `resp_rdata` = 0.
- `req_valid` held high continuously with three alternating sb/lb requests -> each accepted only when `req_ready` = 1, three `resp_valid` pulses spaced 3 cycles apart, no request dropped or duplicated.
- `reset` asserted in the second XFER cycle of an sw to 0x20 -> only 0x20 is written, no `resp_valid`; `req_ready` = 1 the cycle after reset deasserts.
- After reset with no traffic -> all outputs at their reset values; `req_ready` = 1.
